// File: rtl/apple.sv
// rtl/apple.sv - apple placement, eat detection and verified free-cell respawn
// A Galois LFSR proposes cells; each candidate must survive one full body scan before it is committed.
module apple #(
  parameter int          GAME_WIDTH    = 30,
  parameter int          GAME_HEIGHT   = 14,
  parameter int          START_APPLE_X = 20,
  parameter int          START_APPLE_Y = 7,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick_interval,
  input  logic [4:0] i_head_x,
  input  logic [3:0] i_head_y,
  input  logic [4:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic       i_pos_first,
  input  logic       i_pos_last,
  input  logic       i_pos_valid,
  input  logic       i_success,
  output logic       o_eat,
  output logic [4:0] o_apple_x,
  output logic [3:0] o_apple_y,
  output logic       o_apple_valid,
  output logic       o_busy
);

  typedef enum logic [1:0] {IDLE, PICK, WAIT_FIRST, CHECK} state_t;

  localparam logic [4:0] MAX_X = 5'(GAME_WIDTH);
  localparam logic [3:0] MAX_Y = 4'(GAME_HEIGHT);

  state_t      state, state_nx;
  logic [15:0] lfsr, lfsr_nx;
  logic [4:0]  cand_x, cand_x_nx, apple_x_nx;
  logic [3:0]  cand_y, cand_y_nx, apple_y_nx;
  logic        hit, hit_nx, eat_nx, apple_valid_nx;
  logic [4:0]  cx;
  logic [3:0]  cy;
  logic        cand_ok, pos_match, head_on_apple, scan_hit;

  assign lfsr_nx       = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign cx            = lfsr[4:0];
  assign cy            = lfsr[11:8];
  assign cand_ok       = (cx != 5'd0) && (cx <= MAX_X) && (cy != 4'd0) && (cy <= MAX_Y);
  assign pos_match     = (i_pos_x == cand_x) && (i_pos_y == cand_y);
  assign head_on_apple = (i_head_x == o_apple_x) && (i_head_y == o_apple_y);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    hit_nx         = hit;
    cand_x_nx      = cand_x;
    cand_y_nx      = cand_y;
    apple_x_nx     = o_apple_x;
    apple_y_nx     = o_apple_y;
    apple_valid_nx = o_apple_valid;
    eat_nx         = 1'b0;
    scan_hit       = 1'b0;
    case (state)
      IDLE: begin
        if (i_pos_valid && i_pos_first && i_tick_interval && o_apple_valid && head_on_apple) begin
          eat_nx         = 1'b1;
          apple_valid_nx = 1'b0;
          state_nx       = PICK;
        end
      end
      default: begin
        if (i_success) begin
          // Full-length snake: no free cell left to offer, park with no apple.
          apple_valid_nx = 1'b0;
          hit_nx         = 1'b0;
          state_nx       = IDLE;
        end else if (state == PICK) begin
          if (cand_ok) begin
            cand_x_nx = cx;
            cand_y_nx = cy;
            hit_nx    = 1'b0;
            state_nx  = WAIT_FIRST;
          end
        end else if (i_pos_valid && (i_pos_first || state == CHECK)) begin
          // A head element always restarts the scan, discarding earlier hits.
          scan_hit = (i_pos_first ? 1'b0 : hit) | pos_match;
          if (i_pos_last) begin
            hit_nx = 1'b0;
            if (scan_hit) begin
              state_nx = PICK;
            end else begin
              apple_x_nx     = cand_x;
              apple_y_nx     = cand_y;
              apple_valid_nx = 1'b1;
              state_nx       = IDLE;
            end
          end else begin
            hit_nx   = scan_hit;
            state_nx = CHECK;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr          <= LFSR_SEED;
      hit           <= 1'b0;
      cand_x        <= 5'd0;
      cand_y        <= 4'd0;
      o_eat         <= 1'b0;
      o_apple_x     <= 5'(START_APPLE_X);
      o_apple_y     <= 4'(START_APPLE_Y);
      o_apple_valid <= 1'b1;
      o_busy        <= 1'b0;
    end else begin
      lfsr          <= lfsr_nx;
      hit           <= hit_nx;
      cand_x        <= cand_x_nx;
      cand_y        <= cand_y_nx;
      o_eat         <= eat_nx;
      o_apple_x     <= apple_x_nx;
      o_apple_y     <= apple_y_nx;
      o_apple_valid <= apple_valid_nx;
      o_busy        <= (state_nx != IDLE);
    end
  end

endmodule
